// File: rtl/modclk_pkg.sv
// Shared definitions for the modulated-clock configuration loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package modclk_pkg;

  // Field widths of the clock generator selects
  localparam int FREQ_W  = 3;
  localparam int PHASE_W = 5;
  localparam int DUTY_W  = 4;

  // Command byte decoding
  localparam int          CMD_WRITE_BIT = 7;
  localparam logic [7:0]  CMD_COMMIT    = 8'h40;
  localparam logic [7:0]  CMD_CLR_ERR   = 8'h20;

  typedef enum logic [1:0] {
    ADDR_PHASE = 2'd0,
    ADDR_DUTY  = 2'd1,
    ADDR_FREQ  = 2'd2,
    ADDR_SWEEP = 2'd3
  } addr_e;

  typedef enum logic [1:0] {
    S_CMD  = 2'd0,
    S_DATA = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  // Counter width helper that never collapses to a zero-width vector
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/modclk_sync_timer.sv
// Bounds how long a pending commit may wait for a generator period boundary.
// Latency: tc_o asserts combinationally in the SYNC_TIMEOUT-th consecutive enabled cycle.
// Backpressure: none; counts whenever enabled, clears as soon as en_i drops.
// Ports: clk_i, rst_ni (async active-low), en_i (in S_WAIT), tc_o (terminal count).
module modclk_sync_timer
  import modclk_pkg::*;
#(
  parameter int unsigned SYNC_TIMEOUT = 4096
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned    CNT_W = clog2_min1(SYNC_TIMEOUT);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(SYNC_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc_o = en_i && (cnt_q == TERM);

  always_comb begin
    cnt_d = '0;
    if (en_i && !tc_o) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/modclk_cfg_loader.sv
// Byte-stream config loader for the non-overlap clock generator; commits shadow
// selects to the active outputs only on a PERIOD_SYNC boundary (or on timeout).
// Backpressure: CFG_READY drops while a commit is pending in S_WAIT, else always ready.
// Ports: CLK_IN/RST_N; CFG_DATA/CFG_VALID/CFG_READY byte stream; PERIOD_SYNC from the
// generator; FREQ_SEL/PHASE_SEL/DUTY_SEL active selects; PENDING, COMMIT_DONE, CFG_ERR.
// Optional: define MODCLK_SWEEP_EN to build the automatic phase sweep.
module modclk_cfg_loader
  import modclk_pkg::*;
#(
  parameter int unsigned         SYNC_TIMEOUT  = 4096,
  parameter logic [PHASE_W-1:0]  RST_PHASE     = 5'd0,
  parameter logic [DUTY_W-1:0]   RST_DUTY      = 4'd15,
  parameter logic [FREQ_W-1:0]   RST_FREQ      = 3'd0,
  parameter int unsigned         SWEEP_PERIODS = 256
) (
  input  logic               CLK_IN,
  input  logic               RST_N,
  input  logic [7:0]         CFG_DATA,
  input  logic               CFG_VALID,
  output logic               CFG_READY,
  input  logic               PERIOD_SYNC,
  output logic [FREQ_W-1:0]  FREQ_SEL,
  output logic [PHASE_W-1:0] PHASE_SEL,
  output logic [DUTY_W-1:0]  DUTY_SEL,
  output logic               PENDING,
  output logic               COMMIT_DONE,
  output logic               CFG_ERR
);

  state_e             state_q, state_d;
  addr_e              addr_q, addr_d;
  logic [PHASE_W-1:0] sh_phase_q, sh_phase_d, act_phase_q, act_phase_d;
  logic [DUTY_W-1:0]  sh_duty_q, sh_duty_d, act_duty_q, act_duty_d;
  logic [FREQ_W-1:0]  sh_freq_q, sh_freq_d, act_freq_q, act_freq_d;
  logic               pending_q, pending_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               accept;
  logic               commit_apply;
  logic               tmr_tc;

`ifdef MODCLK_SWEEP_EN
  localparam int unsigned        SW_W    = clog2_min1(SWEEP_PERIODS);
  localparam logic [SW_W-1:0]    SW_TERM = SW_W'(SWEEP_PERIODS - 1);
  logic [PHASE_W-1:0] sweep_step_q, sweep_step_d;
  logic [SW_W-1:0]    sweep_cnt_q, sweep_cnt_d;
  logic               step_wr;
`else
  // Parameter kept so builds with and without the sweep share one interface
  logic unused_sweep_periods;
  assign unused_sweep_periods = ^SWEEP_PERIODS;
`endif

  assign CFG_READY   = (state_q != S_WAIT);
  assign accept      = CFG_VALID && CFG_READY;
  assign FREQ_SEL    = act_freq_q;
  assign PHASE_SEL   = act_phase_q;
  assign DUTY_SEL    = act_duty_q;
  assign PENDING     = pending_q;
  assign COMMIT_DONE = done_q;
  assign CFG_ERR     = err_q;

  modclk_sync_timer #(
    .SYNC_TIMEOUT(SYNC_TIMEOUT)
  ) u_timer (
    .clk_i  (CLK_IN),
    .rst_ni (RST_N),
    .en_i   (state_q == S_WAIT),
    .tc_o   (tmr_tc)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    sh_phase_d   = sh_phase_q;
    sh_duty_d    = sh_duty_q;
    sh_freq_d    = sh_freq_q;
    act_phase_d  = act_phase_q;
    act_duty_d   = act_duty_q;
    act_freq_d   = act_freq_q;
    pending_d    = pending_q;
    done_d       = 1'b0;
    err_d        = err_q;
    commit_apply = 1'b0;
`ifdef MODCLK_SWEEP_EN
    step_wr      = 1'b0;
`endif

    case (state_q)
      S_CMD: begin
        // A sync arriving with the commit byte is not looked at here, so the
        // commit always waits for the following boundary.
        if (accept) begin
          if (CFG_DATA[CMD_WRITE_BIT]) begin
            addr_d  = addr_e'(CFG_DATA[1:0]);
            state_d = S_DATA;
          end else if (CFG_DATA == CMD_COMMIT) begin
            pending_d = 1'b1;
            state_d   = S_WAIT;
          end else if (CFG_DATA == CMD_CLR_ERR) begin
            err_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          case (addr_q)
            ADDR_PHASE: sh_phase_d = CFG_DATA[PHASE_W-1:0];
            ADDR_DUTY:  sh_duty_d  = CFG_DATA[DUTY_W-1:0];
            ADDR_FREQ:  sh_freq_d  = CFG_DATA[FREQ_W-1:0];
            ADDR_SWEEP: begin
`ifdef MODCLK_SWEEP_EN
              step_wr = 1'b1;
`else
              err_d = 1'b1;
`endif
            end
            default: ;
          endcase
          state_d = S_CMD;
        end
      end
      S_WAIT: begin
        if (PERIOD_SYNC || tmr_tc) begin
          commit_apply = 1'b1;
          act_phase_d  = sh_phase_q;
          act_duty_d   = sh_duty_q;
          act_freq_d   = sh_freq_q;
          pending_d    = 1'b0;
          done_d       = 1'b1;
          state_d      = S_CMD;
          // A real boundary on the terminal cycle still counts as a clean commit
          if (!PERIOD_SYNC) err_d = 1'b1;
        end
      end
      default: state_d = S_CMD;
    endcase

`ifdef MODCLK_SWEEP_EN
    sweep_step_d = step_wr ? CFG_DATA[PHASE_W-1:0] : sweep_step_q;
    sweep_cnt_d  = sweep_cnt_q;
    if (step_wr) begin
      sweep_cnt_d = '0;
    end else if (commit_apply && PERIOD_SYNC) begin
      // Commit owns this boundary: no step, restart the sweep interval
      sweep_cnt_d = '0;
    end else if (PERIOD_SYNC && (sweep_step_q != '0)) begin
      if (sweep_cnt_q == SW_TERM) begin
        sweep_cnt_d = '0;
        act_phase_d = act_phase_q + sweep_step_q;  // 5-bit wrap
      end else begin
        sweep_cnt_d = sweep_cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_CMD;
      addr_q      <= ADDR_PHASE;
      sh_phase_q  <= RST_PHASE;
      sh_duty_q   <= RST_DUTY;
      sh_freq_q   <= RST_FREQ;
      act_phase_q <= RST_PHASE;
      act_duty_q  <= RST_DUTY;
      act_freq_q  <= RST_FREQ;
      pending_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      sh_phase_q  <= sh_phase_d;
      sh_duty_q   <= sh_duty_d;
      sh_freq_q   <= sh_freq_d;
      act_phase_q <= act_phase_d;
      act_duty_q  <= act_duty_d;
      act_freq_q  <= act_freq_d;
      pending_q   <= pending_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

`ifdef MODCLK_SWEEP_EN
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      sweep_step_q <= '0;
      sweep_cnt_q  <= '0;
    end else begin
      sweep_step_q <= sweep_step_d;
      sweep_cnt_q  <= sweep_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_modclk_cfg_loader.sv
// Directed self-checking bench for modclk_cfg_loader (vector table + corner sequences).
// Latency: n/a.
// Backpressure: byte sender waits on CFG_READY with a bounded cycle budget.
module tb_modclk_cfg_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] cfg_data;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       sync;
  logic [2:0] freq_sel;
  logic [4:0] phase_sel;
  logic [3:0] duty_sel;
  logic       pending;
  logic       commit_done;
  logic       cfg_err;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  modclk_cfg_loader #(
    .SYNC_TIMEOUT (64),
    .RST_PHASE    (5'd0),
    .RST_DUTY     (4'd15),
    .RST_FREQ     (3'd0),
    .SWEEP_PERIODS(4)
  ) dut (
    .CLK_IN      (clk),
    .RST_N       (rst_n),
    .CFG_DATA    (cfg_data),
    .CFG_VALID   (cfg_valid),
    .CFG_READY   (cfg_ready),
    .PERIOD_SYNC (sync),
    .FREQ_SEL    (freq_sel),
    .PHASE_SEL   (phase_sel),
    .DUTY_SEL    (duty_sel),
    .PENDING     (pending),
    .COMMIT_DONE (commit_done),
    .CFG_ERR     (cfg_err)
  );

  always @(negedge clk) if (commit_done) done_cnt++;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input int ph, input int du, input int fr);
    chk({nm, "_phase"}, phase_sel, ph);
    chk({nm, "_duty"},  duty_sel,  du);
    chk({nm, "_freq"},  freq_sel,  fr);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    cfg_data  = b;
    cfg_valid = 1'b1;
    while (!cfg_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cfg_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got ready=0 expected ready=1 for byte %02h", b);
    end
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  // One-cycle sync pulse; returns at the negedge after the sampling edge
  task automatic pulse_sync();
    @(negedge clk);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] dat;
    bit         has_dat;
    int         ph;
    int         du;
    int         fr;
    int         err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int ph, du, fr, bad, d0;
    rst_n = 1'b0; cfg_data = 8'h00; cfg_valid = 1'b0; sync = 1'b0;

    vecs[0] = '{8'h81, 8'hF3, 1'b1,  5,  3, 0, 0};  // duty, MSBs ignored
    vecs[1] = '{8'h82, 8'hFE, 1'b1,  5,  3, 6, 0};  // freq
    vecs[2] = '{8'h80, 8'h3F, 1'b1, 31,  3, 6, 0};  // phase max
    vecs[3] = '{8'h13, 8'h00, 1'b0, 31,  3, 6, 1};  // illegal cmd
    vecs[4] = '{8'hFD, 8'h07, 1'b1, 31,  7, 6, 1};  // write AA=1, err sticky
    vecs[5] = '{8'h20, 8'h00, 1'b0, 31,  7, 6, 0};  // clear err
    vecs[6] = '{8'h55, 8'h00, 1'b0, 31,  7, 6, 1};  // illegal cmd
    vecs[7] = '{8'h20, 8'h00, 1'b0, 31,  7, 6, 0};

    // 1: reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_out("t1_rst", 0, 15, 0);
    chk("t1_ready", cfg_ready, 1);
    chk("t1_err", cfg_err, 0);
    chk("t1_pending", pending, 0);
    chk("t1_done", commit_done, 0);

    // 2: write phase 5, commit, sync 20 cycles later
    send_byte(8'h80);
    send_byte(8'h05);
    send_byte(8'h40);
    @(negedge clk);
    chk("t2_pending", pending, 1);
    chk("t2_ready", cfg_ready, 0);
    d0 = done_cnt;
    bad = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (phase_sel != 5'd0) bad++;
    end
    chk("t2_hold", bad, 0);
    pulse_sync();
    chk_out("t2_apply", 5, 15, 0);
    chk("t2_done", commit_done, 1);
    chk("t2_pending_after", pending, 0);
    repeat (3) @(negedge clk);
    chk("t2_done_count", done_cnt - d0, 1);

    // Vector table: write/cmd, outputs must hold, then commit+sync
    ph = 5; du = 15; fr = 0;
    for (int i = 0; i < 8; i++) begin
      send_byte(vecs[i].cmd);
      if (vecs[i].has_dat) send_byte(vecs[i].dat);
      @(negedge clk);
      chk($sformatf("v%0d_err", i), cfg_err, vecs[i].err);
      chk_out($sformatf("v%0d_hold", i), ph, du, fr);
      send_byte(8'h40);
      pulse_sync();
      chk_out($sformatf("v%0d_apply", i), vecs[i].ph, vecs[i].du, vecs[i].fr);
      chk($sformatf("v%0d_done", i), commit_done, 1);
      ph = vecs[i].ph; du = vecs[i].du; fr = vecs[i].fr;
    end

    // 3: commit accepted in the same cycle as a sync
    send_byte(8'h82);
    send_byte(8'h03);
    @(negedge clk);
    chk("t3_ready", cfg_ready, 1);
    cfg_data = 8'h40; cfg_valid = 1'b1; sync = 1'b1;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0; sync = 1'b0;
    @(negedge clk);
    chk("t3_no_update", freq_sel, 6);
    chk("t3_pending", pending, 1);
    repeat (30) @(negedge clk);
    chk("t3_still_old", freq_sel, 6);
    pulse_sync();
    chk_out("t3_apply", 31, 7, 3);
    chk("t3_done", commit_done, 1);

    // 4: timeout with no sync (SYNC_TIMEOUT=64)
    send_byte(8'h81);
    send_byte(8'h09);
    send_byte(8'h40);
    repeat (63) @(posedge clk);
    #1;
    chk("t4_pending_pre", pending, 1);
    chk("t4_duty_pre", duty_sel, 7);
    chk("t4_err_pre", cfg_err, 0);
    @(posedge clk);
    #1;
    chk("t4_duty", duty_sel, 9);
    chk("t4_err", cfg_err, 1);
    chk("t4_pending", pending, 0);
    chk("t4_done", commit_done, 1);
    send_byte(8'h20);
    @(negedge clk);
    chk("t4_err_clr", cfg_err, 0);

    // 5: illegal byte, then reset while in S_DATA
    send_byte(8'h13);
    @(negedge clk);
    chk("t5_err", cfg_err, 1);
    chk_out("t5_hold", 31, 9, 3);
    send_byte(8'h81);
    send_byte(8'h04);
    send_byte(8'h80);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_out("t5_rst", 0, 15, 0);
    chk("t5_rst_err", cfg_err, 0);
    chk("t5_rst_ready", cfg_ready, 1);
    rst_n = 1'b1;
    send_byte(8'h82);
    send_byte(8'h01);
    send_byte(8'h40);
    pulse_sync();
    chk_out("t5_after_rst", 0, 15, 1);

    // 6: sweep step (or illegal AA=3 without the sweep)
    send_byte(8'h80);
    send_byte(8'h1E);
    send_byte(8'h40);
    pulse_sync();
    chk("t6_phase30", phase_sel, 30);
`ifdef MODCLK_SWEEP_EN
    send_byte(8'h83);
    send_byte(8'h03);
    @(negedge clk);
    chk("t6_step_wr_err", cfg_err, 0);
    for (int i = 0; i < 3; i++) pulse_sync();
    chk("t6_before_step", phase_sel, 30);
    pulse_sync();
    chk("t6_step1", phase_sel, 1);
    for (int i = 0; i < 3; i++) pulse_sync();
    chk("t6_mid", phase_sel, 1);
    pulse_sync();
    chk("t6_step2", phase_sel, 4);
`else
    send_byte(8'h83);
    send_byte(8'h03);
    @(negedge clk);
    chk("t6_sweep_err", cfg_err, 1);
    chk("t6_sweep_hold", phase_sel, 30);
    for (int i = 0; i < 4; i++) pulse_sync();
    chk("t6_no_sweep", phase_sel, 30);
    send_byte(8'h20);
    @(negedge clk);
    chk("t6_err_clr", cfg_err, 0);
    send_byte(8'h40);
    pulse_sync();
    chk("t6_shadow_kept", phase_sel, 30);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
